// File: rtl/qc_seq_pkg.sv
// Shared definitions for the gate-sequence source/multiplier pair:
// default widths, sequencer state encoding and gate code values.
package qc_seq_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int IDX_W_DEF  = 5;
    localparam int GATE_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_FREE   = 3'd1,
        WAIT_ACCEPT = 3'd2,
        WAIT_DONE   = 3'd3,
        FINISH      = 3'd4
    } seq_state_e;

    // Gate codes understood by sequence_multiplier.
    localparam logic [GATE_W_DEF-1:0] GATE_I    = 5'd0;
    localparam logic [GATE_W_DEF-1:0] GATE_X    = 5'd1;
    localparam logic [GATE_W_DEF-1:0] GATE_Y    = 5'd2;
    localparam logic [GATE_W_DEF-1:0] GATE_Z    = 5'd3;
    localparam logic [GATE_W_DEF-1:0] GATE_H    = 5'd4;
    localparam logic [GATE_W_DEF-1:0] GATE_S    = 5'd5;
    localparam logic [GATE_W_DEF-1:0] GATE_SDG  = 5'd6;
    localparam logic [GATE_W_DEF-1:0] GATE_T    = 5'd7;
    localparam logic [GATE_W_DEF-1:0] GATE_TDG  = 5'd8;
    localparam logic [GATE_W_DEF-1:0] GATE_CNOT = 5'd9;

endpackage

// File: rtl/gate_sequence_source_if.sv
// Gate-sequence hand-off between the source (master) and the
// sequence multiplier (slave).
interface gate_sequence_source_if
    import qc_seq_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int GATE_W = GATE_W_DEF
);

    logic [IDX_W-1:0]  seq_index;
    logic [GATE_W-1:0] seq_gate;
    logic              ready;
    logic              first;
    logic              seq_done;
    logic              available;
    logic              mult_done;

    modport master (
        output seq_index,
        output seq_gate,
        output ready,
        output first,
        output seq_done,
        input  available,
        input  mult_done
    );

    modport slave (
        input  seq_index,
        input  seq_gate,
        input  ready,
        input  first,
        input  seq_done,
        output available,
        output mult_done
    );

endinterface

// File: rtl/gate_sequence_source_gate_table.sv
// Gate code register file: one synchronous write port, one combinational
// read port. Contents survive reset; out-of-range writes are dropped.
module gate_table
    import qc_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [GATE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [GATE_W-1:0] rdata
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    logic [GATE_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = we && ({1'b0, waddr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gate_sequence_source.sv
// Streams the programmed gate table from seq_length-1 down to 0 toward the
// sequence multiplier, paced by available, then reports seq_done.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | table writable, waiting for start
// WAIT_FREE   | entry at cursor pending, waiting for available
// WAIT_ACCEPT | entry issued, waiting for consumer to drop available
// WAIT_DONE   | last entry handed off, waiting for mult_done
// FINISH      | seq_done cycle, back to IDLE
module gate_sequence_source
    import qc_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_addr,
    input  logic [GATE_W-1:0]    load_gate,
    input  logic [IDX_W:0]       seq_length,
    input  logic                 start,
    output logic                 busy,
    gate_sequence_source_if.master seq_if
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    seq_state_e        state, state_nxt;
    logic [IDX_W-1:0]  cursor, cursor_nxt;
    logic              first_pend, first_pend_nxt;
    logic [IDX_W-1:0]  index_q, index_nxt;
    logic [GATE_W-1:0] gate_q, gate_nxt;
    logic              ready_q, ready_nxt;
    logic              first_q, first_nxt;
    logic              done_q, done_nxt;

    logic              table_we;
    logic [GATE_W-1:0] rd_gate;
    logic [IDX_W:0]    len_clamped;
    logic [IDX_W:0]    len_m1;

    assign table_we = load_en && (state == IDLE);

    gate_table #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .GATE_W (GATE_W)
    ) u_gate_table (
        .clk   (clk),
        .we    (table_we),
        .waddr (load_addr),
        .wdata (load_gate),
        .raddr (cursor),
        .rdata (rd_gate)
    );

    // Lengths beyond the table stream the whole table.
    assign len_clamped = (seq_length > DEPTH_L) ? DEPTH_L : seq_length;
    assign len_m1      = len_clamped - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cursor     <= '0;
            first_pend <= 1'b0;
            index_q    <= '0;
            gate_q     <= '0;
            ready_q    <= 1'b0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cursor     <= cursor_nxt;
            first_pend <= first_pend_nxt;
            index_q    <= index_nxt;
            gate_q     <= gate_nxt;
            ready_q    <= ready_nxt;
            first_q    <= first_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cursor_nxt     = cursor;
        first_pend_nxt = first_pend;
        index_nxt      = index_q;
        gate_nxt       = gate_q;
        ready_nxt      = 1'b0;
        first_nxt      = 1'b0;
        done_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (seq_length == '0) begin
                        state_nxt = FINISH;
                        done_nxt  = 1'b1;
                    end else begin
                        cursor_nxt     = len_m1[IDX_W-1:0];
                        first_pend_nxt = 1'b1;
                        state_nxt      = WAIT_FREE;
                    end
                end
            end
            WAIT_FREE: begin
                if (seq_if.available) begin
                    index_nxt = cursor;
                    gate_nxt  = rd_gate;
                    ready_nxt = 1'b1;
                    first_nxt = first_pend;
                    state_nxt = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                // Consumer acknowledges by dropping available.
                if (!seq_if.available) begin
                    if (cursor == '0) begin
                        state_nxt = WAIT_DONE;
                    end else begin
                        cursor_nxt     = cursor - 1'b1;
                        first_pend_nxt = 1'b0;
                        state_nxt      = WAIT_FREE;
                    end
                end
            end
            WAIT_DONE: begin
                if (seq_if.mult_done) begin
                    state_nxt = FINISH;
                    done_nxt  = 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy             = (state != IDLE);
    assign seq_if.seq_index = index_q;
    assign seq_if.seq_gate  = gate_q;
    assign seq_if.ready     = ready_q;
    assign seq_if.first     = first_q;
    assign seq_if.seq_done  = done_q;

endmodule

// File: tb/tb_gate_sequence_source.sv
// Directed bench for gate_sequence_source: issue order, pacing, completion,
// reset abort, busy-time writes/starts and length clamping.
module tb_gate_sequence_source;

    localparam int DEPTH  = 32;
    localparam int IDX_W  = 5;
    localparam int GATE_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [IDX_W-1:0]  load_addr;
    logic [GATE_W-1:0] load_gate;
    logic [IDX_W:0]    seq_length;
    logic              start;
    logic              busy;

    gate_sequence_source_if #(.IDX_W(IDX_W), .GATE_W(GATE_W)) sif ();

    gate_sequence_source #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .GATE_W (GATE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_gate  (load_gate),
        .seq_length (seq_length),
        .start      (start),
        .busy       (busy),
        .seq_if     (sif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int ready_wide = 0;
    int done_cnt = 0;
    logic ready_prev = 1'b0;

    // Pulse monitor, settled well before the negedge where the main flow looks.
    always @(posedge clk) begin
        #2;
        if (sif.ready === 1'b1) begin
            ready_cnt++;
            if (ready_prev === 1'b1) ready_wide++;
        end
        ready_prev = sif.ready;
        if (sif.seq_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [GATE_W-1:0] tbl(input int i);
        logic [GATE_W-1:0] v;
        v = (i < 3) ? GATE_W'(i) : GATE_W'(i ^ 10);
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (sif.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic issue(input int exp_idx, input int exp_gate, input bit exp_first,
                         input int gap, input string tag);
        bit ok;
        wait_ready(ok);
        chk({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, "_idx"},   32'(sif.seq_index), 32'(exp_idx));
            chk({tag, "_gate"},  32'(sif.seq_gate),  32'(exp_gate));
            chk({tag, "_first"}, 32'(sif.first),     32'(exp_first));
        end
        sif.available = 1'b0;
        tick();
        chk({tag, "_rdy_low"}, 32'(sif.ready), 32'd0);
        chk({tag, "_hold"},    32'(sif.seq_index), 32'(exp_idx));
        repeat (gap) tick();
    endtask

    task automatic do_start(input int len);
        seq_length = (IDX_W+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_seq(input string tag);
        sif.mult_done = 1'b1;
        tick();
        sif.mult_done = 1'b0;
        chk({tag, "_done"},      32'(sif.seq_done), 32'd1);
        chk({tag, "_busy_fin"},  32'(busy), 32'd1);
        tick();
        chk({tag, "_done_end"},  32'(sif.seq_done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    int rc0, dc0;

    initial begin
        reset = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_gate = '0;
        seq_length = '0;
        start = 1'b0;
        sif.available = 1'b1;
        sif.mult_done = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 32'(sif.ready), 32'd0);
        chk("rst_first", 32'(sif.first), 32'd0);
        chk("rst_done",  32'(sif.seq_done), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_idx",   32'(sif.seq_index), 32'd0);
        chk("rst_gate",  32'(sif.seq_gate), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1;
            load_addr = IDX_W'(i);
            load_gate = tbl(i);
            tick();
        end
        load_en = 1'b0;

        // mult_done in IDLE must not produce seq_done
        dc0 = done_cnt;
        sif.mult_done = 1'b1;
        tick();
        sif.mult_done = 1'b0;
        repeat (2) tick();
        chk("idle_mult_done", 32'(done_cnt - dc0), 32'd0);

        // three-entry stream, slow consumer
        rc0 = ready_cnt;
        sif.available = 1'b1;
        do_start(3);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_latency", 32'(sif.ready), 32'd1);
        issue(2, 2, 1'b1, 50, "t1_e2");
        sif.available = 1'b1;
        issue(1, 1, 1'b0, 50, "t1_e1");
        sif.available = 1'b1;
        issue(0, 0, 1'b0, 50, "t1_e0");
        sif.available = 1'b1;
        chk("t1_ready_cnt",  32'(ready_cnt - rc0), 32'd3);
        chk("t1_ready_wide", 32'(ready_wide), 32'd0);
        chk("t1_wait_done",  32'(sif.seq_done), 32'd0);
        chk("t1_busy_wd",    32'(busy), 32'd1);
        finish_seq("t2");

        // empty sequence
        rc0 = ready_cnt;
        dc0 = done_cnt;
        do_start(0);
        repeat (3) tick();
        chk("t3_done_cnt",  32'(done_cnt - dc0), 32'd1);
        chk("t3_no_ready",  32'(ready_cnt - rc0), 32'd0);
        chk("t3_idle",      32'(busy), 32'd0);

        // consumer not available for 100 cycles
        rc0 = ready_cnt;
        sif.available = 1'b0;
        do_start(3);
        repeat (100) tick();
        chk("t4_no_ready", 32'(ready_cnt - rc0), 32'd0);
        chk("t4_busy",     32'(busy), 32'd1);
        sif.available = 1'b1;
        tick();
        chk("t4_ready_now", 32'(sif.ready), 32'd1);
        issue(2, 2, 1'b1, 2, "t4_e2");
        sif.available = 1'b1;
        issue(1, 1, 1'b0, 2, "t4_e1");
        sif.available = 1'b1;
        issue(0, 0, 1'b0, 2, "t4_e0");
        sif.available = 1'b1;
        finish_seq("t4");

        // reset while the second entry is pending
        sif.available = 1'b1;
        do_start(3);
        issue(2, 2, 1'b1, 2, "t5_e2");
        rc0 = ready_cnt;
        dc0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_ready", 32'(sif.ready), 32'd0);
        chk("t5_first", 32'(sif.first), 32'd0);
        chk("t5_idx",   32'(sif.seq_index), 32'd0);
        chk("t5_gate",  32'(sif.seq_gate), 32'd0);
        chk("t5_busy",  32'(busy), 32'd0);
        sif.available = 1'b1;
        repeat (5) tick();
        chk("t5_no_ready", 32'(ready_cnt - rc0), 32'd0);
        chk("t5_no_done",  32'(done_cnt - dc0), 32'd0);
        do_start(3);
        issue(2, 2, 1'b1, 2, "t5r_e2");
        sif.available = 1'b1;
        issue(1, 1, 1'b0, 2, "t5r_e1");
        sif.available = 1'b1;
        issue(0, 0, 1'b0, 2, "t5r_e0");
        sif.available = 1'b1;
        finish_seq("t5r");

        // clamped length, write and start while busy
        do_start(40);
        issue(31, 21, 1'b1, 2, "t6_e31");
        load_en = 1'b1;
        load_addr = 5'd30;
        load_gate = 5'd7;
        seq_length = 6'd2;
        start = 1'b1;
        tick();
        load_en = 1'b0;
        start = 1'b0;
        sif.available = 1'b1;
        issue(30, 20, 1'b0, 2, "t6_e30");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sif.available = 1'b1;
        tick();

        // single-entry sequence
        do_start(1);
        issue(0, 0, 1'b1, 2, "t7_e0");
        sif.available = 1'b1;
        chk("t7_busy_wd", 32'(busy), 32'd1);
        finish_seq("t7");

        chk("final_ready_wide", 32'(ready_wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
